// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pipe
// Purpose  : Fetch-stage instruction memory with a registered valid/ready
//            response, redirect flush and a back-door loader port.
//            Optional INSTR_MEM_BOUNDS_CHECK_EN faults misaligned or
//            out-of-range fetches and drops such loader writes.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_pipe #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 256,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_data;
    logic             r_rsp_fault;

    logic [IDX_W-1:0] w_req_idx;
    logic [IDX_W-1:0] w_ld_idx;
    logic             w_req_bad;
    logic             w_ld_bad;
    logic             w_accept;
    logic             w_unused;

    assign w_req_idx = req_addr[IDX_W+1:2];
    assign w_ld_idx  = ld_addr[IDX_W+1:2];

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    assign w_req_bad = (req_addr[1:0] != 2'b00) || (|(req_addr >> (IDX_W + 2)));
    assign w_ld_bad  = (ld_addr[1:0]  != 2'b00) || (|(ld_addr  >> (IDX_W + 2)));
`else
    // Addresses wrap modulo DEPTH words; byte offset is ignored.
    assign w_req_bad = 1'b0;
    assign w_ld_bad  = 1'b0;
`endif

    // Address bits outside the word index are only consumed by the bounds check.
    assign w_unused = ^{req_addr, ld_addr};

    // Loader owns the array for the cycle, so fetch never collides with a write.
    assign req_ready = !ld_we && (!r_rsp_valid || rsp_ready || flush);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (ld_we && !w_ld_bad) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= NOP_WORD;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_req_bad ? NOP_WORD : r_mem[w_req_idx];
            r_rsp_fault <= w_req_bad;
        end else if (r_rsp_valid && (rsp_ready || flush)) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_pipe
// Purpose  : Directed scoreboard bench for instr_mem_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        flush;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];   // {fault, data}

    logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};

    instr_mem_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the scoreboard head;
    // the head is retired when the response is consumed or flushed.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data=%h fault=%b with empty scoreboard", rsp_data, rsp_fault);
            end else begin
                if ({rsp_fault, rsp_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rsp_compare: got fault=%b data=%h expected fault=%b data=%h",
                             rsp_fault, rsp_data, exp_q[0][32], exp_q[0][31:0]);
                end
                if (rsp_ready || flush) void'(exp_q.pop_front());
            end
        end
    end

    // Present a request this cycle and record its expected response.
    task automatic request(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_fault);
        req_valid = 1'b1;
        req_addr  = addr;
        exp_q.push_back({exp_fault, exp_data});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        #12;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, NOP);
        chk("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;

        // Load program
        for (int i = 0; i < 4; i++) begin
            ld_we = 1'b1; ld_addr = 32'(i * 4); ld_data = prog[i];
            #1;
            if (i == 0) chk("ld_blocks_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        ld_we = 1'b0;

        // Back-to-back fetch, no bubbles
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            request(32'(i * 4), prog[i], 1'b0);
            #1;
            chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
            tick();
            chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("drained_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Hold: response stable under backpressure, no accept
        rsp_ready = 1'b0;
        request(32'h4, prog[1], 1'b0);
        tick();
        req_valid = 1'b1; req_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_rsp_data", rsp_data, 32'h00A0_0113);
            tick();
        end
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, prog[3]});
        #1;
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();

        // Flush of held 0x8 coinciding with new request for 0x0
        rsp_ready = 1'b0;
        request(32'h8, prog[2], 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        request(32'h0, prog[0], 1'b0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_new_valid", {31'd0, rsp_valid}, 32'd1);
        chk("flush_new_data", rsp_data, 32'h0050_0093);
        rsp_ready = 1'b1;
        tick();
        // Flush while idle is harmless
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_valid", {31'd0, rsp_valid}, 32'd0);

        // Loader blocks fetch; fetch afterwards returns the new word
        req_valid = 1'b1; req_addr = 32'h10;
        ld_we = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
        #1;
        chk("ld_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        ld_we = 1'b0;
        chk("ld_no_rsp", {31'd0, rsp_valid}, 32'd0);
        request(32'h10, 32'hDEAD_BEEF, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("ld_fetch_data", rsp_data, 32'hDEAD_BEEF);
        tick();

        // Reset mid-operation
        rsp_ready = 1'b0;
        request(32'h4, prog[1], 1'b0);
        tick();
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_data", rsp_data, NOP);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        request(32'h0, prog[0], 1'b0);
        tick();
        req_valid = 1'b0;
        chk("postrst_data", rsp_data, 32'h0050_0093);
        tick();

        // Address boundaries
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
        request(32'h2, NOP, 1'b1);
        tick();
        chk("misalign_fault", {31'd0, rsp_fault}, 32'd1);
        request(32'h400, NOP, 1'b1);
        tick();
        chk("oor_fault", {31'd0, rsp_fault}, 32'd1);
        ld_we = 1'b1; ld_addr = 32'h402; ld_data = 32'h1234_5678; req_valid = 1'b0;
        tick();
        ld_we = 1'b0;
        request(32'h0, prog[0], 1'b0);
        tick();
        chk("dropped_ld_data", rsp_data, 32'h0050_0093);
`else
        request(32'h400, prog[0], 1'b0);
        tick();
        chk("wrap_data", rsp_data, 32'h0050_0093);
        chk("wrap_fault", {31'd0, rsp_fault}, 32'd0);
        request(32'h406, prog[1], 1'b0);
        tick();
        chk("wrap_offset_data", rsp_data, 32'h00A0_0113);
`endif
        req_valid = 1'b0;

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
